alarm_ctrl: RTL and testbench

Sequential controller for the home alarm. It takes the raw keypad and sensor inputs, sequences the arm / exit-delay / entry-delay / siren behaviour, and drives the `ALARM` siren output. It sits between the keypad/sensor front end and the siren driver. It replaces purely combinational alarm gating with timed, latched behaviour.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_ctrl_if.sv | 30 +++
 rtl/alarm_timer.sv | 28 ++
 rtl/alarm_ctrl.sv | 122 ++++++++++++
 tb/tb_alarm_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding for the home alarm controller and its timer.
package alarm_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_DISARMED   = 3'd0,
      S_EXIT_WAIT  = 3'd1,
      S_ARMED      = 3'd2,
      S_ENTRY_WAIT = 3'd3,
      S_SIREN      = 3'd4,
      S_SILENT     = 3'd5
   } state_t;

   function automatic logic is_timed(input state_t s);
      return (s == S_EXIT_WAIT) || (s == S_ENTRY_WAIT) || (s == S_SIREN);
   endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Keypad/sensor inputs and status outputs between the front end and alarm_ctrl.
interface alarm_ctrl_if;
   import alarm_pkg::*;

   logic                ARM;
   logic                DISARM;
   logic                PANIC;
   logic                WINDOW;
   logic                DOOR;
   logic                GARAGE;
   logic                ALARM;
   logic                ARMED;
   logic                EXIT_BEEP;
   logic                ENTRY_BEEP;
   logic                TRIPPED;
   logic                ARM_FAULT;
   logic [STATE_W-1:0]  STATE;

   // Front end drives the requests and observes the status.
   modport master (
      output ARM, DISARM, PANIC, WINDOW, DOOR, GARAGE,
      input  ALARM, ARMED, EXIT_BEEP, ENTRY_BEEP, TRIPPED, ARM_FAULT, STATE
   );

   modport slave (
      input  ARM, DISARM, PANIC, WINDOW, DOOR, GARAGE,
      output ALARM, ARMED, EXIT_BEEP, ENTRY_BEEP, TRIPPED, ARM_FAULT, STATE
   );

endinterface

// File: rtl/alarm_timer.sv
// Loadable down-counter for the exit, entry and siren delays.
module alarm_timer #(
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          LOAD,
   input  logic          EN,
   input  logic [CW-1:0] LOAD_VAL,
   output logic          DONE
);

   logic [CW-1:0] count;

   // Counts only while enabled, so the value is frozen in untimed states.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else if (LOAD) begin
         count <= LOAD_VAL;
      end else if (EN && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign DONE = (count == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arm, exit delay, entry grace, siren and latched silent trip.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int EXIT_DLY  = 8,
   parameter int ENTRY_DLY = 6,
   parameter int SIREN_CYC = 16,
   parameter int CW        = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   alarm_ctrl_if.slave   bus
);

   // Timer is loaded with N-1 so each timed state lasts exactly N cycles.
   localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
   localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
   localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);

   state_t        state;
   state_t        state_nxt;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_done;
   logic          fault_nxt;
   logic          fault_q;
   logic          any_sensor;

   assign any_sensor = bus.WINDOW | bus.DOOR | bus.GARAGE;

   alarm_timer #(.CW(CW)) u_timer (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .LOAD     (tmr_load),
      .EN       (is_timed(state)),
      .LOAD_VAL (tmr_val),
      .DONE     (tmr_done)
   );

   // Priority: PANIC > DISARM > sensor/timer events > ARM.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      fault_nxt = 1'b0;
      if (bus.PANIC) begin
         state_nxt = S_SIREN;
         tmr_load  = 1'b1;
         tmr_val   = SIREN_LD;
      end else begin
         case (state)
            S_DISARMED: begin
               if (!bus.DISARM && bus.ARM) begin
                  if (any_sensor) begin
                     fault_nxt = 1'b1;
                  end else begin
                     state_nxt = S_EXIT_WAIT;
                     tmr_load  = 1'b1;
                     tmr_val   = EXIT_LD;
                  end
               end
            end
            S_EXIT_WAIT: begin
               if (bus.DISARM)    state_nxt = S_DISARMED;
               else if (tmr_done) state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (bus.DISARM) begin
                  state_nxt = S_DISARMED;
               end else if (bus.WINDOW) begin
                  state_nxt = S_SIREN;
                  tmr_load  = 1'b1;
                  tmr_val   = SIREN_LD;
               end else if (bus.DOOR || bus.GARAGE) begin
                  state_nxt = S_ENTRY_WAIT;
                  tmr_load  = 1'b1;
                  tmr_val   = ENTRY_LD;
               end
            end
            S_ENTRY_WAIT: begin
               if (bus.DISARM) begin
                  state_nxt = S_DISARMED;
               end else if (bus.WINDOW || tmr_done) begin
                  state_nxt = S_SIREN;
                  tmr_load  = 1'b1;
                  tmr_val   = SIREN_LD;
               end
            end
            S_SIREN: begin
               if (bus.DISARM)    state_nxt = S_DISARMED;
               else if (tmr_done) state_nxt = S_SILENT;
            end
            S_SILENT: begin
               if (bus.DISARM) state_nxt = S_DISARMED;
            end
            default: state_nxt = S_DISARMED;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_DISARMED;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         fault_q <= fault_nxt;
      end
   end

   // Status is decoded only from registered state, so reset clears it at once.
   always_comb begin
      bus.ALARM      = (state == S_SIREN);
      bus.ARMED      = (state == S_ARMED) || (state == S_ENTRY_WAIT);
      bus.EXIT_BEEP  = (state == S_EXIT_WAIT);
      bus.ENTRY_BEEP = (state == S_ENTRY_WAIT);
      bus.TRIPPED    = (state == S_SIREN) || (state == S_SILENT);
      bus.ARM_FAULT  = fault_q;
      bus.STATE      = state;
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed vector bench for alarm_ctrl with short delays (exit 4, entry 3, siren 5).
module tb_alarm_ctrl;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alarm_ctrl_if bus();

   alarm_ctrl #(.EXIT_DLY(4), .ENTRY_DLY(3), .SIREN_CYC(5), .CW(16)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   // Input bit order: {ARM, DISARM, PANIC, WINDOW, DOOR, GARAGE}
   localparam logic [5:0] I0 = 6'b000000;
   localparam logic [5:0] IA = 6'b100000;
   localparam logic [5:0] ID = 6'b010000;
   localparam logic [5:0] IP = 6'b001000;
   localparam logic [5:0] IW = 6'b000100;
   localparam logic [5:0] IR = 6'b000010;
   localparam logic [5:0] IG = 6'b000001;

   typedef struct {
      logic [5:0] in;
      logic [2:0] st;
      logic       flt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] in, input logic [2:0] st, input logic flt);
      vec_t v;
      v.in = in; v.st = st; v.flt = flt;
      vecs.push_back(v);
   endtask

   // Expected {STATE, ALARM, ARMED, EXIT_BEEP, ENTRY_BEEP, TRIPPED, ARM_FAULT}.
   function automatic logic [8:0] expect_out(input logic [2:0] st, input logic flt);
      logic al, ar, eb, nb, tr;
      al = (st == 3'd4);
      ar = (st == 3'd2) || (st == 3'd3);
      eb = (st == 3'd1);
      nb = (st == 3'd3);
      tr = (st == 3'd4) || (st == 3'd5);
      return {st, al, ar, eb, nb, tr, flt};
   endfunction

   function automatic logic [8:0] actual_out();
      return {bus.STATE, bus.ALARM, bus.ARMED, bus.EXIT_BEEP, bus.ENTRY_BEEP,
              bus.TRIPPED, bus.ARM_FAULT};
   endfunction

   task automatic drive(input logic [5:0] in);
      {bus.ARM, bus.DISARM, bus.PANIC, bus.WINDOW, bus.DOOR, bus.GARAGE} = in;
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   task automatic step(input logic [5:0] in);
      @(negedge CLK);
      drive(in);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      drive(I0);
      #1;
      check("reset_async", actual_out(), expect_out(3'd0, 1'b0));
      #12;
      RST_N = 1'b1;

      // Arm and exit delay
      add(I0, 0, 0);
      add(IA, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 1, 0);
      add(I0, 2, 0);
      // Entry delay into siren and silent
      add(IR, 3, 0); add(I0, 3, 0); add(I0, 3, 0);
      add(I0, 4, 0); add(I0, 4, 0); add(I0, 4, 0); add(I0, 4, 0); add(I0, 4, 0);
      add(I0, 5, 0); add(I0, 5, 0);
      add(ID, 0, 0);
      // Disarm in second entry cycle
      add(IA, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 2, 0);
      add(IG, 3, 0); add(ID, 0, 0); add(I0, 0, 0);
      // Instant zone
      add(IA, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 2, 0);
      add(IW, 4, 0); add(ID, 0, 0);
      // PANIC+DISARM, then panic restart in the 4th siren cycle
      add(IP | ID, 4, 0); add(I0, 4, 0); add(I0, 4, 0);
      add(IP, 4, 0); add(I0, 4, 0); add(I0, 4, 0); add(I0, 4, 0); add(I0, 4, 0);
      add(I0, 5, 0); add(ID, 0, 0);
      // Arm rejection, ARM+DISARM
      add(IA | IR, 0, 1); add(IA | IR, 0, 1); add(IA | IR, 0, 1);
      add(I0, 0, 0); add(IA | ID | IW, 0, 0);
      // Sensors ignored in exit, DISARM on the expiry edge
      add(IA, 1, 0); add(IW, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(ID, 0, 0);
      // WINDOW+DOOR in ARMED, and sustained DOOR retrigger after disarm/rearm is blocked
      add(IA, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 1, 0); add(I0, 2, 0);
      add(IW | IR, 4, 0); add(ID | IR, 0, 0); add(IA | IR, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].in);
         check($sformatf("vec%0d", i), actual_out(), expect_out(vecs[i].st, vecs[i].flt));
      end

      // Reset between edges during SIREN drops ALARM without a clock
      step(IP);
      check("panic_siren", actual_out(), expect_out(3'd4, 1'b0));
      @(negedge CLK);
      drive(I0);
      #2;
      RST_N = 1'b0;
      #1;
      check("reset_mid_alarm", actual_out(), expect_out(3'd0, 1'b0));

      // PANIC held through reset fires on the first edge after release
      drive(IP);
      @(posedge CLK);
      #1;
      check("reset_holds", actual_out(), expect_out(3'd0, 1'b0));
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("panic_through_reset", actual_out(), expect_out(3'd4, 1'b0));
      step(ID);
      check("final_disarm", actual_out(), expect_out(3'd0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
